// File: rtl/simple_io_pkg.sv
// ============================================================================
// Module   : simple_io_pkg
// Purpose  : Shared types and constants for the OUT-port serializer slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package simple_io_pkg;

  localparam int WORD_W     = 16;
  localparam int FRAME_BITS = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/out_fifo.sv
// ============================================================================
// Module   : out_fifo
// Purpose  : Synchronous word FIFO with occupancy count; head entry is
//            presented combinationally on rd_data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_fifo
  import simple_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [WORD_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_wr, do_rd;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    count_d  = count_q + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_rd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointer reset alone discards stale contents.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/out_port_serializer.sv
// ============================================================================
// Module   : out_port_serializer
// Purpose  : Buffers 16-bit OUT words and shifts them LSB-first on a UART-style
//            line. Optional macro OUT_PORT_LAST_EN adds the last_value port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_serializer
  import simple_io_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WORD_W-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow,
`ifdef OUT_PORT_LAST_EN
  output logic [WORD_W-1:0]        last_value,
`endif
  output logic                     tx
);

  localparam int DATA_BITS = FRAME_BITS - 2;
  localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_e          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic               pop;
  logic               fifo_empty;
  logic [WORD_W-1:0]  fifo_rd_data;

  out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BAUD_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (wr_en & full);
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Line level is derived from next state so tx changes on the same edge.
    tx_d = 1'b1;
    if (state_d == ST_START) begin
      tx_d = 1'b0;
    end else if (state_d == ST_DATA) begin
      tx_d = shift_d[0];
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

`ifdef OUT_PORT_LAST_EN
  logic [WORD_W-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (wr_en && !full) begin
      last_d = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_value = last_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_out_port_serializer.sv
// ============================================================================
// Module   : tb_out_port_serializer
// Purpose  : Directed self-checking bench for out_port_serializer
//            (covers OUT_PORT_LAST_EN when that macro is defined).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_out_port_serializer;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic [3:0]  count;
  logic        busy;
  logic        overflow;
  logic        tx;
`ifdef OUT_PORT_LAST_EN
  logic [15:0] last_value;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  out_port_serializer #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .count      (count),
    .busy       (busy),
    .overflow   (overflow),
`ifdef OUT_PORT_LAST_EN
    .last_value (last_value),
`endif
    .tx         (tx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge just after the enqueue edge.
  task automatic write_word(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clock);
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Entered at the first sample of the start bit; checks all 18*CPB cycles.
  task automatic check_frame(input string tag, input logic [15:0] w);
    logic [17:0] f;
    f = {1'b1, w, 1'b0};
    for (int b = 0; b < 18; b++) begin
      for (int c = 0; c < CPB; c++) begin
        check($sformatf("%s_tx_b%0d_c%0d", tag, b, c), tx, f[b]);
        if (c == 0) check($sformatf("%s_busy_b%0d", tag, b), busy, 1'b1);
        @(negedge clock);
      end
    end
  endtask

  // Mid-bit sampling receiver with a bounded wait for the start edge.
  task automatic rx_word(output logic [15:0] w);
    int t;
    t = 0;
    w = '0;
    while (tx !== 1'b0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    repeat (CPB/2) @(negedge clock);
    check("rx_start_bit", tx, 1'b0);
    for (int i = 0; i < 16; i++) begin
      repeat (CPB) @(negedge clock);
      w[i] = tx;
    end
    repeat (CPB) @(negedge clock);
    check("rx_stop_bit", tx, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic        saw_low;

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);

    // Single frame
    write_word(16'hA5C3);
    check("single_count_n", count, 4'd1);
    check("single_tx_n", tx, 1'b1);
    check("single_busy_n", busy, 1'b0);
    @(negedge clock);
    check("single_count_load", count, 4'd0);
    check_frame("a5c3", 16'hA5C3);
    check("single_busy_end", busy, 1'b0);
    check("single_tx_end", tx, 1'b1);

    // Back-to-back words
    wr_en   = 1'b1;
    wr_data = 16'h0001;
    @(posedge clock);
    @(negedge clock);
    check("b2b_count_first", count, 4'd1);
    wr_data = 16'hFFFF;
    @(posedge clock);
    @(negedge clock);
    wr_en = 1'b0;
    check("b2b_count_pop_write", count, 4'd1);
    check_frame("w0001", 16'h0001);
    check("b2b_gap_tx", tx, 1'b1);
    check("b2b_gap_busy", busy, 1'b0);
    check("b2b_gap_count", count, 4'd1);
    @(negedge clock);
    check("b2b_count_second_pop", count, 4'd0);
    check_frame("wffff", 16'hFFFF);
    check("b2b_busy_end", busy, 1'b0);

    // Overflow: ten writes while the first frame is in progress
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wr_en   = 1'b1;
          wr_data = 16'(i);
          @(posedge clock);
          @(negedge clock);
          if (i == 0) check("ovf_count_w0", count, 4'd1);
          if (i == 1) check("ovf_count_w1", count, 4'd1);
          if (i == 7) check("ovf_full_w7", full, 1'b0);
          if (i == 8) begin
            check("ovf_count_w8", count, 4'd8);
            check("ovf_full_w8", full, 1'b1);
            check("ovf_flag_w8", overflow, 1'b0);
`ifdef OUT_PORT_LAST_EN
            check("last_w8", last_value, 16'h0008);
`endif
          end
          if (i == 9) begin
            check("ovf_count_w9", count, 4'd8);
            check("ovf_flag_w9", overflow, 1'b1);
`ifdef OUT_PORT_LAST_EN
            check("last_dropped", last_value, 16'h0008);
`endif
          end
        end
        wr_en = 1'b0;
      end
      begin
        for (int j = 0; j < 9; j++) begin
          rx_word(w);
          check($sformatf("ovf_rx_word%0d", j), w, 16'(j));
        end
      end
    join
    repeat (3*CPB) @(negedge clock);
    check("ovf_busy_end", busy, 1'b0);
    check("ovf_count_end", count, 4'd0);
    check("ovf_full_end", full, 1'b0);
    saw_low = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("ovf_no_extra_frame", saw_low, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Reset during data bit 7 (cycles 32..35 of the frame); write held with reset
    write_word(16'h1234);
    @(negedge clock);
    repeat (33) @(negedge clock);
    check("midrst_tx_low_before", tx, 1'b0);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'h7777;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wr_en = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", count, 4'd0);
    check("midrst_overflow", overflow, 1'b0);
    saw_low = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    check("midrst_no_frame", saw_low, 1'b0);
    write_word(16'h0055);
    @(negedge clock);
    check_frame("w0055", 16'h0055);
    check("post_rst_busy_end", busy, 1'b0);

`ifdef OUT_PORT_LAST_EN
    write_word(16'h0010);
    check("last_0010", last_value, 16'h0010);
    write_word(16'h0020);
    check("last_0020", last_value, 16'h0020);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
